mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit (MIPS MULT/MULTU/DIV/DIVU) with HI/LO result registers.

---
 rtl/cmpe200_pkg.sv | 17 +
 rtl/mult_div_unit_sign_fix.sv | 12 +
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmpe200_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package cmpe200_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate; used for abs() on entry and sign restore on exit.
module sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] din,
  input  logic         neg,
  output logic [N-1:0] dout
);

  assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO registers and start/busy/done handshake.
module mult_div_unit
  import cmpe200_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mdu_state_e         state_reg;
  logic [CW-1:0]      step_cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   raw_a_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               zero_div_reg;

  // Operand entry: decode op and take magnitudes of signed operands
  mdu_op_e          op_in;
  logic             signed_op;
  logic             is_div_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign op_in     = mdu_op_e'(op);
  assign signed_op = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign is_div_in = (op_in == MDU_DIVU) || (op_in == MDU_DIV);
  assign a_neg     = signed_op & rs_data[WIDTH-1];
  assign b_neg     = signed_op & rt_data[WIDTH-1];

  sign_fix #(.N(WIDTH)) u_abs_a (.din(rs_data), .neg(a_neg), .dout(abs_a));
  sign_fix #(.N(WIDTH)) u_abs_b (.din(rt_data), .neg(b_neg), .dout(abs_b));

  // Multiply step: acc = {partial, multiplier}; add B on LSB, shift right
  logic [WIDTH:0]     mult_sum;
  logic [2*WIDTH-1:0] mult_next;

  assign mult_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? b_reg : '0)};
  assign mult_next = {mult_sum, acc_reg[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; restoring shift-subtract
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, b_reg};
  // The difference is always smaller than b_reg, so the low WIDTH bits suffice
  assign div_diff  = div_trial[WIDTH-1:0] - b_reg;
  assign div_next  = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};

  // Result sign restore
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  sign_fix #(.N(2*WIDTH)) u_fix_prod (.din(acc_reg), .neg(neg_q_reg), .dout(prod_fixed));
  sign_fix #(.N(WIDTH)) u_fix_quo (.din(acc_reg[WIDTH-1:0]), .neg(neg_q_reg), .dout(quo_fixed));
  sign_fix #(.N(WIDTH)) u_fix_rem (.din(acc_reg[2*WIDTH-1:WIDTH]), .neg(neg_r_reg), .dout(rem_fixed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      step_cnt_reg <= '0;
      acc_reg      <= '0;
      b_reg        <= '0;
      raw_a_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            acc_reg      <= {{WIDTH{1'b0}}, abs_a};
            b_reg        <= abs_b;
            raw_a_reg    <= rs_data;
            is_div_reg   <= is_div_in;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            zero_div_reg <= is_div_in && (rt_data == '0);
            step_cnt_reg <= '0;
            busy         <= 1'b1;
            state_reg    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_reg <= is_div_reg ? div_next : mult_next;
          if (step_cnt_reg == LAST_STEP) begin
            step_cnt_reg <= '0;
            state_reg    <= S_FIX;
          end else begin
            step_cnt_reg <= step_cnt_reg + CW'(1);
          end
        end
        S_FIX: begin
          if (is_div_reg && zero_div_reg) begin
            hi          <= raw_a_reg;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div_reg) begin
            hi          <= rem_fixed;
            lo          <= quo_fixed;
            div_by_zero <= 1'b0;
          end else begin
            hi          <= prod_fixed[2*WIDTH-1:WIDTH];
            lo          <= prod_fixed[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (W=32): results, latency, busy length, hold and reset behaviour.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op, then wait (bounded) for done. Returns latency in edges after
  // the start edge, number of cycles busy was high, and whether hi/lo held steady before done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcyc, output bit hold_ok);
    logic [W-1:0] h0, l0;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = busy ? 1 : 0;
    lat = -1;
    hold_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy) bcyc++;
      if (done) begin
        lat = i;
        break;
      end
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
    end
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h dz=%0b latency=%0d busy=%0d",
             o, a, b, hi, lo, div_by_zero, lat, bcyc);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, div_by_zero, hi, lo} !== {3'b000, 64'h0})
      $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bcyc; bit hold;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo, div_by_zero} !== {64'hFFFF_FFFE_0000_0001, 1'b0})
      $display("FAIL multu_max got hi=%h lo=%h dz=%b want hi=fffffffe lo=00000001 dz=0", hi, lo, div_by_zero);
    else pass_cnt++;
    total_cnt++;
    if (lat != 33 || bcyc != 33 || !hold)
      $display("FAIL multu_timing got latency=%0d busy=%0d hold=%0b want 33/33/1", lat, bcyc, hold);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_pulse got done=%b busy=%b one cycle later want 0/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_mult;
    int lat, bcyc; bit hold;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1 || lat != 33 || !hold)
      $display("FAIL mult_neg got hi=%h lo=%h lat=%0d hold=%0b want ffffffff/fffffff1/33/1", hi, lo, lat, hold);
    else pass_cnt++;
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000 || lat != 33)
      $display("FAIL mult_minmin got hi=%h lo=%h lat=%0d want 40000000/00000000/33", hi, lo, lat);
    else pass_cnt++;
  endtask

  task automatic test_div;
    int lat, bcyc; bit hold;
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo, div_by_zero} !== {64'hFFFF_FFFF_FFFF_FFFD, 1'b0} || lat != 33 || bcyc != 33)
      $display("FAIL div_neg7_2 got hi=%h lo=%h dz=%b lat=%0d want ffffffff/fffffffd/0/33", hi, lo, div_by_zero, lat);
    else pass_cnt++;
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD || lat != 33)
      $display("FAIL div_7_neg2 got hi=%h lo=%h lat=%0d want 00000001/fffffffd/33", hi, lo, lat);
    else pass_cnt++;
    run_op(2'b10, 32'd7, 32'd2, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003 || lat != 33)
      $display("FAIL divu_7_2 got hi=%h lo=%h lat=%0d want 00000001/00000003/33", hi, lo, lat);
    else pass_cnt++;
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000 || lat != 33)
      $display("FAIL div_overflow got hi=%h lo=%h lat=%0d want 00000000/80000000/33", hi, lo, lat);
    else pass_cnt++;
  endtask

  task automatic test_div_by_zero;
    int lat, bcyc; bit hold;
    run_op(2'b10, 32'd9, 32'd0, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo, div_by_zero} !== {64'h0000_0009_FFFF_FFFF, 1'b1} || lat != 33 || bcyc != 33)
      $display("FAIL divu_zero got hi=%h lo=%h dz=%b lat=%0d want 00000009/ffffffff/1/33", hi, lo, div_by_zero, lat);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (div_by_zero !== 1'b1)
      $display("FAIL dz_hold got dz=%b want 1", div_by_zero);
    else pass_cnt++;
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo, div_by_zero} !== {64'hFFFF_FFF9_FFFF_FFFF, 1'b1} || lat != 33)
      $display("FAIL div_zero_raw got hi=%h lo=%h dz=%b want fffffff9/ffffffff/1", hi, lo, div_by_zero);
    else pass_cnt++;
    run_op(2'b00, 32'd2, 32'd3, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo, div_by_zero} !== {64'h0000_0000_0000_0006, 1'b0} || lat != 33)
      $display("FAIL dz_clear got hi=%h lo=%h dz=%b want 00000000/00000006/0", hi, lo, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int lat2;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd6; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 6) begin
        start = 1'b1; op = 2'b11; rs_data = 32'd1; rt_data = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    $display("op=0 rs=6 rt=7 (ignored start at cycle 5) -> hi=%h lo=%h latency=%0d", hi, lo, lat);
    total_cnt++;
    if ({hi, lo} !== 64'd42 || lat != 33)
      $display("FAIL busy_ignore got hi=%h lo=%h lat=%0d want 00000000/0000002a/33", hi, lo, lat);
    else pass_cnt++;
    // Start the next op during the done cycle; it must be accepted immediately
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL start_in_done got busy=%b want 1", busy);
    else pass_cnt++;
    lat2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat2 = i;
        break;
      end
    end
    $display("op=0 rs=3 rt=3 (started in done cycle) -> hi=%h lo=%h latency=%0d", hi, lo, lat2);
    total_cnt++;
    if ({hi, lo} !== 64'd9 || lat2 != 33)
      $display("FAIL done_cycle_op got hi=%h lo=%h lat=%0d want 00000000/00000009/33", hi, lo, lat2);
    else pass_cnt++;
    repeat (36) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd9)
      $display("FAIL no_queue got busy=%b done=%b lo=%h want 0/0/00000009", busy, done, lo);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int lat, bcyc; bit hold;
    run_op(2'b00, 32'd6, 32'd7, lat, bcyc, hold);
    total_cnt++;
    if (lo !== 32'd42)
      $display("FAIL preload got lo=%h want 0000002a", lo);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset during divu 100/7 -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    total_cnt++;
    if ({busy, done, div_by_zero, hi, lo} !== {3'b000, 64'h0})
      $display("FAIL async_reset got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle got busy=%b done=%b want 0/0", busy, done);
    else pass_cnt++;
    run_op(2'b10, 32'd100, 32'd7, lat, bcyc, hold);
    total_cnt++;
    if ({hi, lo} !== 64'h0000_0002_0000_000E || lat != 33 || bcyc != 33)
      $display("FAIL divu_after_reset got hi=%h lo=%h lat=%0d want 00000002/0000000e/33", hi, lo, lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_by_zero;
    test_back_to_back;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
